// File: rtl/shift_seq_pkg.sv
// Shared types and default sizes for the multi-cycle shift unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: shift_op_t opcode encodings, shift_state_t FSM encodings, default widths.
package shift_seq_pkg;

    localparam int XLEN_DEFAULT    = 32;
    localparam int SHAMT_W_DEFAULT = 5;

    // Opcode 2'b10 is reserved and is executed as a left shift.
    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_RSV = 2'b10,
        OP_SRA = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Single-step shift datapath: one 1-bit or one 4-bit shift of the operand.
// Latency: purely combinational.
// Backpressure: none, no state.
// Ports: i_data operand, i_op opcode, i_step4 selects the 4-bit step, o_data result.
// The caller only raises i_step4 when the fast-step build (SHIFT_SEQ_FAST_EN) is enabled.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] i_data,
    input  logic [1:0]      i_op,
    input  logic            i_step4,
    output logic [XLEN-1:0] o_data
);

    logic            w_right;
    logic            w_fill;
    logic [XLEN-1:0] w_sh1_l;
    logic [XLEN-1:0] w_sh1_r;
    logic [XLEN-1:0] w_sh4_l;
    logic [XLEN-1:0] w_sh4_r;

    // Reserved opcode falls into the left-shift path because only SRL/SRA go right.
    assign w_right = (i_op == OP_SRL) || (i_op == OP_SRA);
    // Bit shifted in at the top: sign bit for SRA, zero otherwise.
    assign w_fill  = (i_op == OP_SRA) & i_data[XLEN-1];

    assign w_sh1_l = {i_data[XLEN-2:0], 1'b0};
    assign w_sh1_r = {w_fill, i_data[XLEN-1:1]};
    assign w_sh4_l = {i_data[XLEN-5:0], 4'b0000};
    assign w_sh4_r = {{4{w_fill}}, i_data[XLEN-1:4]};

    assign o_data = i_step4 ? (w_right ? w_sh4_r : w_sh4_l)
                            : (w_right ? w_sh1_r : w_sh1_l);

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit iterating a small step datapath under an IDLE/SHIFT/DONE FSM.
// Latency: accept at T -> out_valid at T+1+shamt (T+1+shamt/4+shamt%4 with SHIFT_SEQ_FAST_EN).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts.
// Ports: clk/reset (sync, active-high), flush, in_valid/in_ready/in_op/in_data/in_shamt request,
//        out_valid/out_ready/out_data result, busy = SHIFT or DONE.
// Optional macro SHIFT_SEQ_FAST_EN adds a 4-bit step when the remaining count is at least 4.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_W = SHAMT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [XLEN-1:0]    in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_data,
    output logic               busy
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]         r_state;
    logic [XLEN-1:0]    r_data;
    logic [1:0]         r_op;
    logic [SHAMT_W-1:0] r_count;

    logic               w_step4;
    logic [XLEN-1:0]    w_step_data;
    logic [SHAMT_W-1:0] w_count_nxt;

`ifdef SHIFT_SEQ_FAST_EN
    assign w_step4 = (r_count >= SHAMT_W'(4));
`else
    assign w_step4 = 1'b0;
`endif

    assign w_count_nxt = r_count - (w_step4 ? SHAMT_W'(4) : SHAMT_W'(1));

    shift_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_data  (r_data),
        .i_op    (r_op),
        .i_step4 (w_step4),
        .o_data  (w_step_data)
    );

    // Count is never zero while in SHIFT: a zero amount goes straight to DONE on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_op    <= 2'b00;
            r_count <= '0;
        end else if (flush) begin
            // Abort leaves the data register as-is; only the FSM is returned to IDLE.
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_op    <= in_op;
                        r_count <= in_shamt;
                        r_state <= (in_shamt == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_data  <= w_step_data;
                    r_count <= w_count_nxt;
                    if (w_count_nxt == '0) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign out_data  = r_data;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer.
// Latency: expected cycle counts follow the build (SHIFT_SEQ_FAST_EN aware).
// Backpressure: exercises out_ready hold, flush and reset in DONE.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    shift_sequencer #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input int sh);
`ifdef SHIFT_SEQ_FAST_EN
        return 1 + sh / 4 + sh % 4;
`else
        return 1 + sh;
`endif
    endfunction

    // Issues one request from IDLE and waits (bounded) for out_valid.
    // lat is the cycle offset from the accept edge; busy_ok clears if busy ever dropped.
    task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                          output int lat, output logic busy_ok);
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        busy_ok  = 1'b1;
        while (out_valid !== 1'b1 && lat < 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (busy !== 1'b1) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_sll31();
        int lat; logic bok;
        run_op(2'b00, 32'h0000_0001, 5'd31, lat, bok);
        total++; if (lat !== exp_lat(31)) begin bad++; $display("FAIL sll31_latency: got %0d want %0d", lat, exp_lat(31)); end
        total++; if (out_data !== 32'h8000_0000) begin bad++; $display("FAIL sll31_data: got %h want 80000000", out_data); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL sll31_busy: got busy drop want busy high throughout"); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sll31_idle: got in_ready %b want 1", in_ready); end
    endtask

    task automatic test_sra_srl();
        int lat; logic bok;
        run_op(2'b11, 32'h8000_0000, 5'd4, lat, bok);
        total++; if (lat !== exp_lat(4)) begin bad++; $display("FAIL sra4_latency: got %0d want %0d", lat, exp_lat(4)); end
        total++; if (out_data !== 32'hF800_0000) begin bad++; $display("FAIL sra4_data: got %h want f8000000", out_data); end
        tick();
        run_op(2'b01, 32'h8000_0000, 5'd4, lat, bok);
        total++; if (out_data !== 32'h0800_0000) begin bad++; $display("FAIL srl4_data: got %h want 08000000", out_data); end
        tick();
        run_op(2'b11, 32'h7000_0000, 5'd8, lat, bok);
        total++; if (out_data !== 32'h0070_0000) begin bad++; $display("FAIL sra8_pos_data: got %h want 00700000", out_data); end
        tick();
    endtask

    task automatic test_shamt0();
        int lat; logic bok;
        run_op(2'b01, 32'hDEAD_BEEF, 5'd0, lat, bok);
        total++; if (lat !== 1) begin bad++; $display("FAIL shamt0_latency: got %0d want 1", lat); end
        total++; if (out_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL shamt0_data: got %h want deadbeef", out_data); end
        tick();
    endtask

    task automatic test_hold();
        int lat; logic bok;
        out_ready = 1'b0;
        run_op(2'b00, 32'h0000_0003, 5'd2, lat, bok);
        total++; if (out_data !== 32'h0000_000C) begin bad++; $display("FAIL hold_data: got %h want 0000000c", out_data); end
        // A competing request while the result is held must not be taken.
        in_data  = 32'hFFFF_FFFF;
        in_shamt = 5'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid_%0d: got %b want 1", i, out_valid); end
            total++; if (out_data !== 32'h0000_000C) begin bad++; $display("FAIL hold_stable_%0d: got %h want 0000000c", i, out_data); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready_%0d: got %b want 0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_no_accept: got busy %b want 0", busy); end
    endtask

    task automatic test_flush();
        int lat; logic bok; logic seen;
        logic [31:0] exp_partial;
`ifdef SHIFT_SEQ_FAST_EN
        exp_partial = 32'h0001_0000;
`else
        exp_partial = 32'h0000_0010;
`endif
        seen     = 1'b0;
        in_op    = 2'b00;
        in_data  = 32'h0000_0001;
        in_shamt = 5'd20;
        in_valid = 1'b1;
        tick();                         // now cycle T+1
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick();                     // ends at cycle T+5
        end
        if (out_valid !== 1'b0) seen = 1'b1;
        flush = 1'b1;
        tick();                         // cycle T+6
        flush = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_idle: got in_ready %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0 || seen) begin bad++; $display("FAIL flush_no_valid: got out_valid %b seen %b want 0 0", out_valid, seen); end
        total++; if (out_data !== exp_partial) begin bad++; $display("FAIL flush_data_kept: got %h want %h", out_data, exp_partial); end
        run_op(2'b01, 32'h0000_00F0, 5'd4, lat, bok);
        total++; if (lat !== exp_lat(4)) begin bad++; $display("FAIL post_flush_latency: got %0d want %0d", lat, exp_lat(4)); end
        total++; if (out_data !== 32'h0000_000F) begin bad++; $display("FAIL post_flush_data: got %h want 0000000f", out_data); end
        tick();
        // flush beats in_valid in IDLE
        in_data  = 32'h1234_5678;
        in_shamt = 5'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL flush_blocks_accept: got in_ready %b busy %b want 1 0", in_ready, busy); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_blocks_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_done();
        int lat; logic bok;
        out_ready = 1'b0;
        run_op(2'b00, 32'h0000_0005, 5'd1, lat, bok);
        total++; if (out_data !== 32'h0000_000A || out_valid !== 1'b1) begin bad++; $display("FAIL rst_done_pre: got data %h valid %b want 0000000a 1", out_data, out_valid); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_done_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_done_data: got %h want 00000000", out_data); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_done_in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
    endtask

    task automatic test_reserved();
        int lat; logic bok;
        run_op(2'b10, 32'h0000_0001, 5'd3, lat, bok);
        total++; if (lat !== exp_lat(3)) begin bad++; $display("FAIL rsv_latency: got %0d want %0d", lat, exp_lat(3)); end
        total++; if (out_data !== 32'h0000_0008) begin bad++; $display("FAIL rsv_data: got %h want 00000008", out_data); end
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = 32'h0;
        in_shamt  = 5'd0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_sll31();
        test_sra_srl();
        test_shamt0();
        test_hold();
        test_flush();
        test_reset_done();
        test_reserved();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
